// File: rtl/alu_sequencer_pkg.sv
// Shared execute-stage definitions: RV32I instruction and format enums,
// ALU operation codes, sequencer FSM states, PC increment constant and a
// helper that turns a branch compare result into a taken decision.
package alu_sequencer_pkg;

    typedef enum logic [5:0] {
        LUI, AUIPC, JAL, JALR,
        BEQ, BNE, BLT, BGE, BLTU, BGEU,
        LB, LH, LW, LBU, LHU, SB, SH, SW,
        ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI,
        ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
        FENCE, ECALL, EBREAK
    } rv32i_base_instr;

    typedef enum logic [2:0] {
        R_TYPE, I_TYPE, S_TYPE, B_TYPE, U_TYPE, J_TYPE
    } rv32i_base_instr_type;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_op_e;

    typedef enum logic [2:0] {
        S_IDLE, S_EXEC, S_BR_CMP, S_BR_TGT, S_JMP, S_DONE
    } seq_state_e;

    localparam int PC_INCR = 4;

    // BEQ/BNE compare with SUB (zero test); the ordered branches use
    // SLT/SLTU whose result lives in bit 0.
    function automatic logic branch_cond(rv32i_base_instr op, logic res_zero, logic res_lsb);
        case (op)
            BEQ:        return res_zero;
            BNE:        return !res_zero;
            BLT, BLTU:  return res_lsb;
            BGE, BGEU:  return !res_lsb;
            default:    return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_sequencer_decode.sv
// alu_op_decode: combinational opcode -> ALU operation map.
// Ports:
//   opcode_i       decoded RV32I instruction
//   alu_op_o       ALU operation for the primary (or only) ALU pass
//   unsupported_o  opcode has no execute-stage implementation
module alu_op_decode
    import alu_sequencer_pkg::*;
(
    input  rv32i_base_instr opcode_i,
    output alu_op_e         alu_op_o,
    output logic            unsupported_o
);

    always_comb begin
        alu_op_o      = ALU_ADD;
        unsupported_o = 1'b0;
        case (opcode_i)
            // Address generation and upper-immediate forms all add.
            LUI, AUIPC, JAL, JALR,
            LB, LH, LW, LBU, LHU, SB, SH, SW,
            ADDI, ADD:                  alu_op_o = ALU_ADD;
            SUB, BEQ, BNE:              alu_op_o = ALU_SUB;
            SLT, SLTI, BLT, BGE:        alu_op_o = ALU_SLT;
            SLTU, SLTIU, BLTU, BGEU:    alu_op_o = ALU_SLTU;
            XOR, XORI:                  alu_op_o = ALU_XOR;
            OR, ORI:                    alu_op_o = ALU_OR;
            AND, ANDI:                  alu_op_o = ALU_AND;
            SLL, SLLI:                  alu_op_o = ALU_SLL;
            SRL, SRLI:                  alu_op_o = ALU_SRL;
            SRA, SRAI:                  alu_op_o = ALU_SRA;
            // FENCE/ECALL/EBREAK and any stray encoding
            default:                    unsupported_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: execute-stage controller for the multi-cycle RV32I core.
// Takes one instruction through a valid/ready issue handshake, drives the
// shared ALU for one pass (ALU ops, jumps) or two passes (taken branch:
// compare then pc+imm), and presents the result through valid/ready.
// Ports:
//   clk_i, rst_i                       clock, synchronous active-high reset
//   issue_valid_i / issue_ready_o      issue handshake
//   opcode_i, instr_type_i, pc_i,
//   rs1_data_i, rs2_data_i, imm_value_i  decoded instruction fields
//   kill_i                             abort in-flight instruction
//   alu_src_a_o, alu_src_b_o, alu_op_o drive the shared ALU
//   alu_result_i                       combinational ALU result
//   result_valid_o / result_ready_i    result handshake
//   rd_data_o, branch_taken_o,
//   next_pc_o, illegal_o               result payload
module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    issue_valid_i,
    output logic                    issue_ready_o,
    input  rv32i_base_instr         opcode_i,
    input  rv32i_base_instr_type    instr_type_i,
    input  logic [ADDR_WIDTH-1:0]   pc_i,
    input  logic [DATA_WIDTH-1:0]   rs1_data_i,
    input  logic [DATA_WIDTH-1:0]   rs2_data_i,
    input  logic [DATA_WIDTH-1:0]   imm_value_i,
    input  logic                    kill_i,
    output logic [DATA_WIDTH-1:0]   alu_src_a_o,
    output logic [DATA_WIDTH-1:0]   alu_src_b_o,
    output alu_op_e                 alu_op_o,
    input  logic [DATA_WIDTH-1:0]   alu_result_i,
    output logic                    result_valid_o,
    input  logic                    result_ready_i,
    output logic [DATA_WIDTH-1:0]   rd_data_o,
    output logic                    branch_taken_o,
    output logic [ADDR_WIDTH-1:0]   next_pc_o,
    output logic                    illegal_o
);

    seq_state_e             state;
    rv32i_base_instr        opcode_q;
    logic [ADDR_WIDTH-1:0]  pc_q;
    logic [DATA_WIDTH-1:0]  imm_q;
    logic                   valid_q;

    alu_op_e                dec_op;
    logic                   dec_unsupported;
    logic                   accept;
    logic                   br_taken;
    logic [ADDR_WIDTH-1:0]  pc_q_plus4;
    logic [ADDR_WIDTH-1:0]  pc_i_plus4;
    logic [ADDR_WIDTH-1:0]  jmp_target;

    alu_op_decode u_decode (
        .opcode_i      (opcode_i),
        .alu_op_o      (dec_op),
        .unsupported_o (dec_unsupported)
    );

    // kill_i in IDLE refuses the issue; reset masks both handshakes.
    assign issue_ready_o  = (state == S_IDLE) && !kill_i && !rst_i;
    assign accept         = issue_valid_i && issue_ready_o;
    // A kill coinciding with result_ready_i must not deliver the result.
    assign result_valid_o = valid_q && !kill_i && !rst_i;

    // Local incrementers so the link address never costs an ALU pass.
    assign pc_q_plus4 = pc_q + ADDR_WIDTH'(PC_INCR);
    assign pc_i_plus4 = pc_i + ADDR_WIDTH'(PC_INCR);
    assign br_taken   = branch_cond(opcode_q, alu_result_i == '0, alu_result_i[0]);

    always_comb begin
        jmp_target = ADDR_WIDTH'(alu_result_i);
        if (opcode_q == JALR) jmp_target[0] = 1'b0;
    end

    // rs1/rs2 are consumed on the first ALU pass, so they are latched
    // straight into the operand output registers; only what a later pass
    // needs (opcode, pc, imm) is held separately.
    always_ff @(posedge clk_i) begin
        if (rst_i || (kill_i && state != S_IDLE)) begin
            state          <= S_IDLE;
            opcode_q       <= ADD;
            pc_q           <= '0;
            imm_q          <= '0;
            valid_q        <= 1'b0;
            alu_src_a_o    <= '0;
            alu_src_b_o    <= '0;
            alu_op_o       <= ALU_ADD;
            rd_data_o      <= '0;
            branch_taken_o <= 1'b0;
            next_pc_o      <= '0;
            illegal_o      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        opcode_q  <= opcode_i;
                        pc_q      <= pc_i;
                        imm_q     <= imm_value_i;
                        illegal_o <= 1'b0;
                        if (dec_unsupported) begin
                            rd_data_o      <= '0;
                            next_pc_o      <= pc_i_plus4;
                            branch_taken_o <= 1'b0;
                            illegal_o      <= 1'b1;
                            valid_q        <= 1'b1;
                            state          <= S_DONE;
                        end else if (instr_type_i == B_TYPE) begin
                            alu_src_a_o <= rs1_data_i;
                            alu_src_b_o <= rs2_data_i;
                            alu_op_o    <= dec_op;
                            state       <= S_BR_CMP;
                        end else if (opcode_i == JAL || opcode_i == JALR) begin
                            alu_src_a_o <= (opcode_i == JAL) ? DATA_WIDTH'(pc_i) : rs1_data_i;
                            alu_src_b_o <= imm_value_i;
                            alu_op_o    <= ALU_ADD;
                            state       <= S_JMP;
                        end else begin
                            if (opcode_i == LUI)
                                alu_src_a_o <= '0;
                            else if (opcode_i == AUIPC)
                                alu_src_a_o <= DATA_WIDTH'(pc_i);
                            else
                                alu_src_a_o <= rs1_data_i;
                            alu_src_b_o <= (instr_type_i inside {I_TYPE, S_TYPE, U_TYPE, J_TYPE})
                                           ? imm_value_i : rs2_data_i;
                            alu_op_o    <= dec_op;
                            state       <= S_EXEC;
                        end
                    end
                end
                S_EXEC: begin
                    rd_data_o      <= alu_result_i;
                    next_pc_o      <= pc_q_plus4;
                    branch_taken_o <= 1'b0;
                    valid_q        <= 1'b1;
                    alu_src_a_o    <= '0;
                    alu_src_b_o    <= '0;
                    alu_op_o       <= ALU_ADD;
                    state          <= S_DONE;
                end
                S_BR_CMP: begin
                    if (br_taken) begin
                        // second pass computes the target
                        alu_src_a_o <= DATA_WIDTH'(pc_q);
                        alu_src_b_o <= imm_q;
                        alu_op_o    <= ALU_ADD;
                        state       <= S_BR_TGT;
                    end else begin
                        rd_data_o      <= '0;
                        next_pc_o      <= pc_q_plus4;
                        branch_taken_o <= 1'b0;
                        valid_q        <= 1'b1;
                        alu_src_a_o    <= '0;
                        alu_src_b_o    <= '0;
                        alu_op_o       <= ALU_ADD;
                        state          <= S_DONE;
                    end
                end
                S_BR_TGT: begin
                    rd_data_o      <= '0;
                    next_pc_o      <= ADDR_WIDTH'(alu_result_i);
                    branch_taken_o <= 1'b1;
                    valid_q        <= 1'b1;
                    alu_src_a_o    <= '0;
                    alu_src_b_o    <= '0;
                    alu_op_o       <= ALU_ADD;
                    state          <= S_DONE;
                end
                S_JMP: begin
                    rd_data_o      <= DATA_WIDTH'(pc_q_plus4);
                    next_pc_o      <= jmp_target;
                    branch_taken_o <= 1'b1;
                    valid_q        <= 1'b1;
                    alu_src_a_o    <= '0;
                    alu_src_b_o    <= '0;
                    alu_op_o       <= ALU_ADD;
                    state          <= S_DONE;
                end
                S_DONE: begin
                    // single entry: the next issue waits for IDLE
                    if (result_ready_i) begin
                        valid_q <= 1'b0;
                        state   <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
